// File: rtl/dma_round_robin_arbiter_if.sv
// Handshake bundle between one round-robin priority level, the fixed-priority
// arbiter above it and the transfer controller.
interface dma_round_robin_arbiter_if #(
  parameter int unsigned NUM_OF_BDS       = 4,
  parameter int unsigned NUM_OF_BDS_WIDTH = 2
);
  logic [NUM_OF_BDS-1:0]       bdReq;
  logic                        strReq;
  logic                        reqEn;
  logic                        tranDone;
  logic                        req;
  logic [NUM_OF_BDS_WIDTH-1:0] intDscrptrNum;
  logic                        strDscrptr;
  logic                        busy;

  modport master (
    output bdReq, strReq, reqEn, tranDone,
    input  req, intDscrptrNum, strDscrptr, busy
  );

  modport slave (
    input  bdReq, strReq, reqEn, tranDone,
    output req, intDscrptrNum, strDscrptr, busy
  );
endinterface

// File: rtl/dma_round_robin_arbiter.sv
// Round-robin arbiter over the buffer descriptors (plus optional stream slot) of
// one priority level; offers a winner upstream and holds it until the transfer ends.
module dma_round_robin_arbiter #(
  parameter int unsigned NUM_OF_BDS       = 4,
  parameter int unsigned NUM_OF_BDS_WIDTH = 2,
  parameter int unsigned STR_SLOT_EN      = 0
) (
  input logic                    clock,
  input logic                    resetn,
  dma_round_robin_arbiter_if.slave bus
);

  localparam int unsigned N     = NUM_OF_BDS + STR_SLOT_EN;
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [PTR_W-1:0]            slot_q, slot_d;
  logic                        req_q, req_d;
  logic [NUM_OF_BDS_WIDTH-1:0] num_q, num_d;
  logic                        str_q, str_d;
  logic                        busy_q, busy_d;

  logic [N-1:0]                req_vec_c;
  logic [PTR_W-1:0]            idx_c;
  logic [PTR_W-1:0]            win_slot_c;
  logic                        win_valid_c;
  logic                        win_is_str_c;
  logic [PTR_W-1:0]            ptr_next_c;

  // Stream slot sits just above the BDs when present.
  if (STR_SLOT_EN != 0) begin : g_str
    assign req_vec_c = {bus.strReq, bus.bdReq};
  end else begin : g_nostr
    logic unused_str_c;
    assign req_vec_c    = bus.bdReq;
    assign unused_str_c = bus.strReq;
  end

  // First requesting slot at or after the pointer, wrapping modulo N.
  always_comb begin
    win_valid_c = 1'b0;
    win_slot_c  = '0;
    idx_c       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = ((32'(ptr_q) + k) >= N) ? PTR_W'(32'(ptr_q) + k - N)
                                       : PTR_W'(32'(ptr_q) + k);
      if (!win_valid_c && req_vec_c[idx_c]) begin
        win_valid_c = 1'b1;
        win_slot_c  = idx_c;
      end
    end
  end

  assign win_is_str_c = (STR_SLOT_EN != 0) && (32'(win_slot_c) == NUM_OF_BDS);
  assign ptr_next_c   = (32'(slot_q) == (N - 1)) ? '0 : slot_q + PTR_W'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      slot_q  <= '0;
      req_q   <= 1'b0;
      num_q   <= '0;
      str_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      req_q   <= req_d;
      num_q   <= num_d;
      str_q   <= str_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    req_d   = req_q;
    num_d   = num_q;
    str_d   = str_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (win_valid_c) begin
          slot_d  = win_slot_c;
          str_d   = win_is_str_c;
          num_d   = win_is_str_c ? '0 : NUM_OF_BDS_WIDTH'(win_slot_c);
          req_d   = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // A grant in the same cycle as a withdrawal still wins.
        if (bus.reqEn) begin
          ptr_d   = ptr_next_c;
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = HOLD;
        end else if (!req_vec_c[slot_q]) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.tranDone) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req           = req_q;
  assign bus.intDscrptrNum = num_q;
  assign bus.strDscrptr    = str_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dma_round_robin_arbiter.sv
// Directed and random checks of two arbiter instances (without / with stream slot)
// against a slot-rotation reference model.
module tb_dma_round_robin_arbiter;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic [3:0] bd_req;
  logic       str_req;
  logic       req_en;
  logic       tran_done;

  dma_round_robin_arbiter_if #(.NUM_OF_BDS(4), .NUM_OF_BDS_WIDTH(2)) if0 ();
  dma_round_robin_arbiter_if #(.NUM_OF_BDS(4), .NUM_OF_BDS_WIDTH(2)) if1 ();

  assign if0.bdReq    = bd_req;
  assign if0.strReq   = str_req;
  assign if0.reqEn    = req_en;
  assign if0.tranDone = tran_done;
  assign if1.bdReq    = bd_req;
  assign if1.strReq   = str_req;
  assign if1.reqEn    = req_en;
  assign if1.tranDone = tran_done;

  dma_round_robin_arbiter #(.NUM_OF_BDS(4), .NUM_OF_BDS_WIDTH(2), .STR_SLOT_EN(0)) dut0 (
    .clock (clock),
    .resetn(resetn),
    .bus   (if0.slave)
  );

  dma_round_robin_arbiter #(.NUM_OF_BDS(4), .NUM_OF_BDS_WIDTH(2), .STR_SLOT_EN(1)) dut1 (
    .clock (clock),
    .resetn(resetn),
    .bus   (if1.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: phase 0 waiting, 1 offered, 2 granted; slots are plain integers.
  int   m_phase[2];
  int   m_ptr[2];
  int   m_slot[2];
  int   m_num[2];
  logic m_req[2];
  logic m_str[2];
  logic m_busy[2];

  function automatic int pick(input int ptr, input int n, input logic [4:0] rv);
    for (int k = 0; k < n; k++) begin
      if (rv[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_ptr[d] = 0; m_slot[d] = 0; m_num[d] = 0;
      m_req[d] = 1'b0; m_str[d] = 1'b0; m_busy[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n;
      int w;
      logic [4:0] rv;
      n  = (d == 0) ? 4 : 5;
      rv = {((d == 1) ? str_req : 1'b0), bd_req};
      case (m_phase[d])
        0: begin
          w = pick(m_ptr[d], n, rv);
          if (w >= 0) begin
            m_slot[d]  = w;
            m_str[d]   = (w == 4);
            m_num[d]   = (w == 4) ? 0 : w;
            m_req[d]   = 1'b1;
            m_phase[d] = 1;
          end
        end
        1: begin
          if (req_en) begin
            m_ptr[d]   = (m_slot[d] + 1) % n;
            m_req[d]   = 1'b0;
            m_busy[d]  = 1'b1;
            m_phase[d] = 2;
          end else if (!rv[m_slot[d]]) begin
            m_req[d]   = 1'b0;
            m_phase[d] = 0;
          end
        end
        2: begin
          if (tran_done) begin
            m_busy[d]  = 1'b0;
            m_phase[d] = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("d0_outputs", {3'b0, if0.req, if0.busy, if0.strDscrptr, if0.intDscrptrNum},
          {3'b0, m_req[0], m_busy[0], m_str[0], 2'(m_num[0])});
    check("d1_outputs", {3'b0, if1.req, if1.busy, if1.strDscrptr, if1.intDscrptrNum},
          {3'b0, m_req[1], m_busy[1], m_str[1], 2'(m_num[1])});
  endtask

  task automatic cycle();
    @(posedge clock);
    if (resetn) model_step();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic wait_req(input int d, input string tag);
    logic r;
    for (int t = 0; t < 12; t++) begin
      r = (d == 0) ? if0.req : if1.req;
      if (r === 1'b1) break;
      cycle();
    end
    r = (d == 0) ? if0.req : if1.req;
    check(tag, {7'b0, r}, 8'h01);
  endtask

  task automatic grant_round(input int exp_num, input string tag);
    wait_req(0, {tag, "_req"});
    check({tag, "_num"}, {6'b0, if0.intDscrptrNum}, 8'(exp_num));
    req_en = 1'b1; cycle(); req_en = 1'b0;
    cycle(); cycle();
    tran_done = 1'b1; cycle(); tran_done = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; bd_req = 4'b0; str_req = 1'b0; req_en = 1'b0; tran_done = 1'b0;
    model_reset();
    cycle(); cycle();
    check("reset_d0", {3'b0, if0.req, if0.busy, if0.strDscrptr, if0.intDscrptrNum}, 8'h00);
    check("reset_d1", {3'b0, if1.req, if1.busy, if1.strDscrptr, if1.intDscrptrNum}, 8'h00);
    resetn = 1'b1;

    // All BDs requesting: strict rotation.
    bd_req = 4'b1111;
    grant_round(0, "rr0"); grant_round(1, "rr1"); grant_round(2, "rr2");
    grant_round(3, "rr3"); grant_round(0, "rr4");

    // Single persistent requester re-granted as the pointer wraps.
    bd_req = 4'b0100;
    grant_round(2, "one_a"); grant_round(2, "one_b"); grant_round(2, "one_c");

    // Withdrawal without grant: back to idle, pointer untouched (still 3).
    bd_req = 4'b0010;
    wait_req(0, "wd_req");
    check("wd_num", {6'b0, if0.intDscrptrNum}, 8'd1);
    bd_req = 4'b0000; cycle();
    check("wd_dropped", {6'b0, if0.req, if0.busy}, 8'h00);
    bd_req = 4'b1010;
    grant_round(3, "wd_ptr_kept");

    // Withdrawal with simultaneous grant: grant honoured, pointer moves to 2.
    bd_req = 4'b0010;
    wait_req(0, "wg_req");
    bd_req = 4'b0000; req_en = 1'b1; cycle(); req_en = 1'b0;
    check("wg_hold", {6'b0, if0.req, if0.busy}, 8'h01);
    tran_done = 1'b1; cycle(); tran_done = 1'b0;
    bd_req = 4'b0111;
    wait_req(0, "wg_next_req");
    check("wg_ptr2", {6'b0, if0.intDscrptrNum}, 8'd2);

    // Spurious strobes in the wrong state change nothing.
    tran_done = 1'b1; cycle(); tran_done = 1'b0;
    check("sp_offer", {5'b0, if0.req, if0.intDscrptrNum}, 8'h06);
    req_en = 1'b1; cycle(); req_en = 1'b0;
    req_en = 1'b1; cycle(); req_en = 1'b0;
    check("sp_hold", {6'b0, if0.req, if0.busy}, 8'h01);

    // Asynchronous reset while holding a grant.
    #2 resetn = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("arst_d0", {3'b0, if0.req, if0.busy, if0.strDscrptr, if0.intDscrptrNum}, 8'h00);
    check("arst_d1", {3'b0, if1.req, if1.busy, if1.strDscrptr, if1.intDscrptrNum}, 8'h00);
    cycle();
    bd_req = 4'b1000; resetn = 1'b1;
    grant_round(3, "post_rst3");
    resetn = 1'b0; model_reset(); cycle();
    bd_req = 4'b1111; resetn = 1'b1;
    grant_round(0, "post_rst_slot0");

    bd_req = 4'b0000;
    req_en = 1'b1; cycle(); req_en = 1'b0;
    check("sp_idle", {6'b0, if0.req, if0.busy}, 8'h00);

    // Stream slot alone: only the stream-enabled instance offers.
    str_req = 1'b1;
    wait_req(1, "str_req");
    check("str_flag", {5'b0, if1.strDscrptr, if1.intDscrptrNum}, 8'h04);
    check("str_ignored_d0", {7'b0, if0.req}, 8'h00);
    req_en = 1'b1; cycle(); req_en = 1'b0;
    tran_done = 1'b1; cycle(); tran_done = 1'b0;
    bd_req = 4'b1000;
    wait_req(1, "str_wrap_req");
    check("str_wrap_ptr0", {5'b0, if1.strDscrptr, if1.intDscrptrNum}, 8'h03);
    req_en = 1'b1; cycle(); req_en = 1'b0;
    tran_done = 1'b1; cycle(); tran_done = 1'b0;

    // Random traffic, every cycle compared to the model.
    for (int i = 0; i < 2000; i++) begin
      if (($urandom % 4) == 0) bd_req = 4'($urandom);
      str_req   = 1'($urandom % 2);
      req_en    = (($urandom % 3) == 0);
      tran_done = (($urandom % 4) == 0);
      if (($urandom % 250) == 0) begin
        resetn = 1'b0;
        model_reset();
      end else begin
        resetn = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_round_robin_arbiter.md
DMA_ROUND_ROBIN_ARBITER -- requirements
Module: dma_round_robin_arbiter

Interface
REQ-001 Parameter NUM_OF_BDS, default 4: number of internal buffer descriptors (BDs) arbitrated at this priority level.
REQ-002 Parameter NUM_OF_BDS_WIDTH, default 2: width of descriptor number, equal to ceil(log2(NUM_OF_BDS)).
REQ-003 Parameter STR_SLOT_EN, default 0: 1 adds one stream-descriptor slot, index NUM_OF_BDS, to the rotation; set to 1 only on the priority-0 instance.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 bdReq  input  NUM_OF_BDS  per-BD request, level; bit i high means BD i is valid and ready at this priority.
REQ-007 strReq  input  1  stream-descriptor request, level; ignored when STR_SLOT_EN=0.
REQ-008 reqEn  input  1  one-cycle grant strobe from the downstream fixed-priority arbiter bit for this level.
REQ-009 tranDone  input  1  one-cycle pulse from the transfer controller: granted descriptor finished.
REQ-010 req  output  1  registered request to the fixed-priority arbiter.
REQ-011 intDscrptrNum  output  NUM_OF_BDS_WIDTH  registered winning BD number.
REQ-012 strDscrptr  output  1  registered flag: winner is the stream slot.
REQ-013 busy  output  1  high in HOLD state.

Function
REQ-014 Slot count N = NUM_OF_BDS + STR_SLOT_EN; request vector = {strReq if enabled, bdReq}.
REQ-015 Rotation pointer ptr, width sufficient for N-1, marks the highest-priority slot; the winner is the first requesting slot scanning ptr, ptr+1, ..., wrapping modulo N.
REQ-016 FSM states: IDLE, OFFER, HOLD.
REQ-017 IDLE: if any request is high, register the winner into intDscrptrNum/strDscrptr, set req=1, go OFFER next cycle; otherwise stay IDLE with req=0.
REQ-018 OFFER: req, intDscrptrNum, strDscrptr are held constant; no re-arbitration while in OFFER.
REQ-019 OFFER with reqEn=1: ptr <= (winner+1) mod N, req <= 0, go HOLD.
REQ-020 OFFER with reqEn=0 and the registered winner's request low: withdraw; req <= 0, go IDLE, ptr unchanged.
REQ-021 OFFER with reqEn=1 in the same cycle as winner withdrawal: the grant is honored (REQ-019 applies).
REQ-022 HOLD: req=0, busy=1, outputs intDscrptrNum/strDscrptr hold the granted values; on tranDone go IDLE.
REQ-023 Latency: request rising in IDLE at edge k gives req=1 after edge k+1; after tranDone at edge k, earliest new req=1 after edge k+2.
REQ-024 reqEn outside OFFER and tranDone outside HOLD are ignored: no state, pointer or output change.
REQ-025 Pointer wrap: winner N-1 gives ptr=0; a single persistent requester is re-granted every round.
REQ-026 intDscrptrNum=0 whenever strDscrptr=1; strDscrptr is constant 0 when STR_SLOT_EN=0.

Reset
REQ-027 resetn low, at any time including mid-OFFER/HOLD, immediately sets state=IDLE, ptr=0, req=0, intDscrptrNum=0, strDscrptr=0, busy=0.
REQ-028 First arbitration after reset favours slot 0.

Verification
REQ-029 bdReq=4'b1111 held; reqEn one cycle after each req rise; tranDone 3 cycles after each reqEn -> grants in order 0,1,2,3,0.
REQ-030 bdReq=4'b0100 only, repeated grant/tranDone cycles -> intDscrptrNum=2 every round, ptr wraps 3->... and grant still 2.
REQ-031 STR_SLOT_EN=1, bdReq=4'b0000, strReq=1 -> req=1, strDscrptr=1, intDscrptrNum=0; after grant ptr=0.
REQ-032 OFFER for BD1, drop bdReq[1] with reqEn=0 -> req=0 next cycle, state IDLE, ptr unchanged; same drop with reqEn=1 -> HOLD, ptr=2.
REQ-033 Assert resetn=0 in HOLD -> all outputs 0 asynchronously; after release with bdReq=4'b1000 -> intDscrptrNum=3.
REQ-034 Spurious reqEn in IDLE/HOLD and spurious tranDone in OFFER -> no change to state, ptr or any output.
